// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte FIFO behind uart_rx with FWFT read port and overrun tracking
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_done,
  input  logic                       rd_ready,
  output logic [7:0]                 rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overrun,
  input  logic                       overrun_clr,
  output logic [7:0]                 drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    drop_count_q, drop_count_d;
  logic          push, pop, drop;

  // Flags come only from registered count, so rd_ready never reaches an output combinationally.
  assign rd_valid    = (count_q != '0);
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AF_C);
  assign count       = count_q;
  assign overrun     = overrun_q;
  assign drop_count  = drop_count_q;
  assign rd_data     = rd_valid ? mem_q[rd_ptr_q] : 8'h00;

  assign pop  = rd_valid & rd_ready;
  assign push = rx_done & (~full | pop);
  assign drop = rx_done & full & ~pop;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overrun_d    = overrun_q;
    drop_count_d = drop_count_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear wins and restarts the tally at one.
    if (drop) begin
      overrun_d = 1'b1;
      if (overrun_clr)                drop_count_d = 8'd1;
      else if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    end else if (overrun_clr) begin
      overrun_d    = 1'b0;
      drop_count_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overrun_q    <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overrun_q    <= overrun_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

endmodule
